a_rf_loader: RTL and testbench

- Control stage directly upstream of the A-operand register file (8-entry shift RF, 30-bit words, single or dual 27-bit read).
- Accepts a 30-bit A stream over valid/ready and shifts a programmed number of words into the RF via A/RF_load.
- Then sequences RF read addresses (A_addr) and MDR for a programmed number of sweeps, flagging each valid multiplier operand cycle to downstream.

---
 rtl/a_rf_pkg.sv | 36 +++
 rtl/a_rf_addr_gen.sv | 62 ++++++
 rtl/a_rf_loader.sv | 156 +++++++++++++++
 tb/tb_a_rf_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_rf_pkg.sv
// Shared types and constants for the A-operand register file and its loader.
package a_rf_pkg;

  localparam int unsigned RF_DEPTH  = 8;
  localparam int unsigned RF_ADDR_W = $clog2(RF_DEPTH);
  localparam int unsigned DATA_W    = 30;
  localparam int unsigned LEN_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READ   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] reps;
    logic             mdr;
  } cfg_t;

  // A job is legal when 1 <= len <= RF_DEPTH, reps >= 1, and dual-read jobs
  // use an even length so every pair {RF[a+1], RF[a]} lies inside the load.
  function automatic logic cfg_is_legal(input logic [LEN_W-1:0] len,
                                        input logic [LEN_W-1:0] reps,
                                        input logic             mdr);
    logic ok;
    ok = (len != 4'd0) && (len <= LEN_W'(RF_DEPTH)) && (reps != 4'd0);
    if (mdr && len[0]) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/a_rf_addr_gen.sv
// Down-counting RF read address generator: step 1 or 2, wraps to the start
// address at the end of each sweep and flags the last address of the last sweep.
module a_rf_addr_gen
  import a_rf_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 adv_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [LEN_W-1:0]     reps_i,
  input  logic                 step2_i,
  output logic [RF_ADDR_W-1:0] addr_o,
  output logic                 last_o
);

  logic [RF_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]     sweep_q, sweep_d;
  logic [RF_ADDR_W-1:0] start_addr_s;
  logic [RF_ADDR_W-1:0] step_s;
  logic                 sweep_end_s;

  // Oldest word sits at len-1; dual reads start one lower so addr+1 stays in range.
  assign start_addr_s = step2_i ? RF_ADDR_W'(len_i - 4'd2) : RF_ADDR_W'(len_i - 4'd1);
  assign step_s       = step2_i ? 3'd2 : 3'd1;
  assign sweep_end_s  = (addr_q == 3'd0);
  assign last_o       = sweep_end_s && (sweep_q == (reps_i - 4'd1));
  assign addr_o       = addr_q;

  // Next address / sweep count: load on start, step down or wrap on advance, else hold.
  always_comb begin
    addr_d  = addr_q;
    sweep_d = sweep_q;
    if (start_i) begin
      addr_d  = start_addr_s;
      sweep_d = 4'd0;
    end else if (adv_i) begin
      if (sweep_end_s) begin
        addr_d  = start_addr_s;
        sweep_d = sweep_q + 4'd1;
      end else begin
        addr_d  = addr_q - step_s;
        sweep_d = sweep_q;
      end
    end else begin
      addr_d  = addr_q;
      sweep_d = sweep_q;
    end
  end

  // Address and sweep registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= 3'd0;
      sweep_q <= 4'd0;
    end else begin
      addr_q  <= addr_d;
      sweep_q <= sweep_d;
    end
  end

endmodule

// File: rtl/a_rf_loader.sv
// Loads a programmed number of stream words into the A shift RF, then walks
// the RF read address for a programmed number of sweeps, flagging each valid
// multiplier operand cycle.
module a_rf_loader
  import a_rf_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 cfg_start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_mdr,
  input  logic [LEN_W-1:0]     cfg_reps,
  input  logic                 cfg_abort,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 s_ready,
  output logic [DATA_W-1:0]    A,
  output logic                 RF_load,
  output logic                 MDR,
  output logic [RF_ADDR_W-1:0] A_addr,
  output logic                 mult_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  state_e              state_q;
  cfg_t                cfg_q;
  logic [LEN_W-1:0]    acc_cnt_q;
  logic [DATA_W-1:0]   a_q;
  logic                rf_load_q;
  logic                mdr_q;
  logic                mult_valid_q;
  logic                s_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                cfg_err_q;

  logic                accept_s;
  logic                ag_start_s;
  logic                ag_adv_s;
  logic                ag_last_s;
  logic [RF_ADDR_W-1:0] ag_addr_s;

  assign accept_s = s_valid & s_ready_q;

  // The generator is primed during SETTLE so the first READ cycle already
  // shows the start address; abort freezes it so A_addr holds.
  assign ag_start_s = (state_q == ST_SETTLE) && !cfg_abort;
  assign ag_adv_s   = (state_q == ST_READ) && !ag_last_s && !cfg_abort;

  a_rf_addr_gen u_addr_gen (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .start_i (ag_start_s),
    .adv_i   (ag_adv_s),
    .len_i   (cfg_q.len),
    .reps_i  (cfg_q.reps),
    .step2_i (cfg_q.mdr),
    .addr_o  (ag_addr_s),
    .last_o  (ag_last_s)
  );

  // Control FSM with all outputs registered; abort overrides every transition.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      acc_cnt_q    <= 4'd0;
      a_q          <= '0;
      rf_load_q    <= 1'b0;
      mdr_q        <= 1'b0;
      mult_valid_q <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      rf_load_q <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (cfg_abort) begin
        state_q      <= ST_IDLE;
        s_ready_q    <= 1'b0;
        mult_valid_q <= 1'b0;
        mdr_q        <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cfg_start) begin
              if (cfg_is_legal(cfg_len, cfg_reps, cfg_mdr)) begin
                cfg_q.len  <= cfg_len;
                cfg_q.reps <= cfg_reps;
                cfg_q.mdr  <= cfg_mdr;
                acc_cnt_q  <= 4'd0;
                s_ready_q  <= 1'b1;
                busy_q     <= 1'b1;
                state_q    <= ST_LOAD;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            if (accept_s) begin
              a_q       <= s_data;
              rf_load_q <= 1'b1;
              acc_cnt_q <= acc_cnt_q + 4'd1;
              // Dropping ready on the final accept edge guarantees no extra word.
              if ((acc_cnt_q + 4'd1) == cfg_q.len) begin
                s_ready_q <= 1'b0;
                mdr_q     <= cfg_q.mdr;
                state_q   <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            mult_valid_q <= 1'b1;
            state_q      <= ST_READ;
          end
          ST_READ: begin
            if (ag_last_s) begin
              mult_valid_q <= 1'b0;
              mdr_q        <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            s_ready_q    <= 1'b0;
            mult_valid_q <= 1'b0;
            mdr_q        <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign s_ready    = s_ready_q;
  assign A          = a_q;
  assign RF_load    = rf_load_q;
  assign MDR        = mdr_q;
  assign A_addr     = ag_addr_s;
  assign mult_valid = mult_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_a_rf_loader.sv
// Self-checking bench for a_rf_loader: directed jobs plus randomized jobs
// compared against a job-level reference model.
module tb_a_rf_loader;

  logic        CLK;
  logic        RSTN;
  logic        cfg_start;
  logic [3:0]  cfg_len;
  logic        cfg_mdr;
  logic [3:0]  cfg_reps;
  logic        cfg_abort;
  logic        s_valid;
  logic [29:0] s_data;
  logic        s_ready;
  logic [29:0] A;
  logic        RF_load;
  logic        MDR;
  logic [2:0]  A_addr;
  logic        mult_valid;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int          checks;
  int          errors;
  logic [29:0] a_model;

  a_rf_loader dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .cfg_start  (cfg_start),
    .cfg_len    (cfg_len),
    .cfg_mdr    (cfg_mdr),
    .cfg_reps   (cfg_reps),
    .cfg_abort  (cfg_abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .A          (A),
    .RF_load    (RF_load),
    .MDR        (MDR),
    .A_addr     (A_addr),
    .mult_valid (mult_valid),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input int len, input int reps, input bit mdr);
    return (len >= 1) && (len <= 8) && (reps >= 1) && !(mdr && (len % 2 == 1));
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_A"}, 32'(A), 0);
    chk({tag, "_rfload"}, 32'(RF_load), 0);
    chk({tag, "_mdr"}, 32'(MDR), 0);
    chk({tag, "_addr"}, 32'(A_addr), 0);
    chk({tag, "_mv"}, 32'(mult_valid), 0);
    chk({tag, "_ready"}, 32'(s_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(cfg_err), 0);
  endtask

  task automatic reject_job(input int len, input int reps, input bit mdr);
    cfg_len   = 4'(len);
    cfg_reps  = 4'(reps);
    cfg_mdr   = mdr;
    cfg_start = 1'b1;
    s_valid   = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("rej_err", 32'(cfg_err), 1);
    chk("rej_busy", 32'(busy), 0);
    chk("rej_ready", 32'(s_ready), 0);
    tick();
    chk("rej_err_clr", 32'(cfg_err), 0);
    chk("rej_busy2", 32'(busy), 0);
    chk("rej_rfload", 32'(RF_load), 0);
    s_valid = 1'b0;
  endtask

  // One job from start to done (or abort / reset). Expected outputs come from
  // the job rules: word k arrives, shows up on A one cycle later, SETTLE one
  // cycle after the last accept, then reps sweeps of start - i*step.
  task automatic run_job(input int len, input int reps, input bit mdr,
                         input logic [31:0] vmask, input bit rnd,
                         input logic [29:0] base, input int abort_at, input int rst_at);
    int          acc;
    int          c;
    int          n;
    int          st;
    int          step;
    int          k;
    logic [29:0] word;
    cfg_len   = 4'(len);
    cfg_reps  = 4'(reps);
    cfg_mdr   = mdr;
    cfg_start = 1'b1;
    s_valid   = 1'b0;
    tick();
    cfg_start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_err", 32'(cfg_err), 0);
    acc = 0;
    c   = 0;
    while (acc < len && c < 200) begin
      if (acc == rst_at) begin
        RSTN = 1'b0;
        #1;
        chk_all_zero("rst_async");
        a_model = 30'd0;
        tick();
        tick();
        RSTN    = 1'b1;
        s_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("post_rst_ready", 32'(s_ready), 0);
          chk("post_rst_rfload", 32'(RF_load), 0);
          chk("post_rst_busy", 32'(busy), 0);
        end
        s_valid = 1'b0;
        return;
      end
      chk("load_ready", 32'(s_ready), 1);
      chk("load_mv", 32'(mult_valid), 0);
      chk("load_mdr", 32'(MDR), 0);
      s_valid = rnd ? ($urandom_range(0, 2) != 0) : ((c < 32) ? vmask[c] : 1'b1);
      word    = (base != 30'd0) ? (base + 30'(acc)) : 30'($urandom);
      s_data  = word;
      tick();
      c++;
      if (s_valid) begin
        acc++;
        a_model = word;
        chk("load_rfload_on", 32'(RF_load), 1);
      end else begin
        chk("load_rfload_off", 32'(RF_load), 0);
      end
      chk("load_A", 32'(A), 32'(a_model));
    end
    chk("load_count", acc, len);
    // SETTLE: final pulse already checked; MDR must now be driven.
    chk("settle_ready", 32'(s_ready), 0);
    chk("settle_mdr", 32'(MDR), 32'(mdr));
    chk("settle_mv", 32'(mult_valid), 0);
    s_valid = 1'b1;
    s_data  = 30'($urandom);
    tick();
    n    = mdr ? len / 2 : len;
    st   = mdr ? len - 2 : len - 1;
    step = mdr ? 2 : 1;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < n; i++) begin
        k = r * n + i;
        chk("rd_mv", 32'(mult_valid), 1);
        chk("rd_addr", 32'(A_addr), st - i * step);
        chk("rd_mdr", 32'(MDR), 32'(mdr));
        chk("rd_rfload", 32'(RF_load), 0);
        chk("rd_ready", 32'(s_ready), 0);
        chk("rd_err", 32'(cfg_err), 0);
        chk("rd_A", 32'(A), 32'(a_model));
        if (rnd) begin
          cfg_start = 1'($urandom_range(0, 1));
          cfg_len   = 4'($urandom);
          cfg_reps  = 4'($urandom);
          cfg_mdr   = 1'($urandom);
        end
        if (k == abort_at) begin
          cfg_abort = 1'b1;
          tick();
          cfg_abort = 1'b0;
          cfg_start = 1'b0;
          chk("abort_mv", 32'(mult_valid), 0);
          chk("abort_busy", 32'(busy), 0);
          chk("abort_ready", 32'(s_ready), 0);
          chk("abort_rfload", 32'(RF_load), 0);
          chk("abort_done", 32'(done), 0);
          chk("abort_addr_hold", 32'(A_addr), st - i * step);
          tick();
          chk("abort_done2", 32'(done), 0);
          chk("abort_busy2", 32'(busy), 0);
          s_valid = 1'b0;
          return;
        end
        tick();
      end
    end
    cfg_start = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("done_mv", 32'(mult_valid), 0);
    chk("done_mdr", 32'(MDR), 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_addr_hold", 32'(A_addr), 0);
    chk("done_err", 32'(cfg_err), 0);
    s_valid = 1'b0;
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(s_ready), 0);
  endtask

  initial begin
    int  len;
    int  reps;
    bit  mdr;
    checks    = 0;
    errors    = 0;
    a_model   = 30'd0;
    RSTN      = 1'b0;
    cfg_start = 1'b0;
    cfg_len   = 4'd0;
    cfg_mdr   = 1'b0;
    cfg_reps  = 4'd0;
    cfg_abort = 1'b0;
    s_valid   = 1'b0;
    s_data    = 30'd0;
    #12;
    chk_all_zero("reset");
    @(negedge CLK);
    RSTN = 1'b1;
    s_valid = 1'b1;
    tick();
    tick();
    chk("idle_ignore_valid", 32'(RF_load), 0);
    chk("idle_ready0", 32'(s_ready), 0);
    s_valid = 1'b0;

    // Back-to-back load of 8, one sweep.
    run_job(8, 1, 1'b0, 32'hFFFF_FFFF, 1'b0, 30'h11, -1, -1);
    // Load 4 with gaps on the stream, valid only on cycles 0,2,3,6 then high.
    run_job(4, 1, 1'b0, 32'hFFFF_FF4D, 1'b0, 30'h100, -1, -1);
    // Dual read, len 6, two sweeps.
    run_job(6, 2, 1'b1, 32'hFFFF_FFFF, 1'b0, 30'h200, -1, -1);
    // Rejected configurations.
    reject_job(0, 1, 1'b0);
    reject_job(9, 1, 1'b0);
    reject_job(4, 0, 1'b0);
    reject_job(5, 1, 1'b1);
    // Abort on the second READ cycle, then a normal job.
    run_job(8, 1, 1'b0, 32'hFFFF_FFFF, 1'b0, 30'h300, 1, -1);
    run_job(3, 2, 1'b0, 32'hFFFF_FFFF, 1'b0, 30'h400, -1, -1);
    // Asynchronous reset after three accepts, then a normal job.
    run_job(8, 1, 1'b0, 32'hFFFF_FFFF, 1'b0, 30'h500, -1, 3);
    run_job(2, 3, 1'b1, 32'hFFFF_FFFF, 1'b0, 30'h600, -1, -1);

    // Randomized jobs, legal and illegal.
    for (int t = 0; t < 30; t++) begin
      len  = $urandom_range(0, 10);
      reps = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      mdr  = 1'($urandom_range(0, 1));
      if (model_legal(len, reps, mdr)) begin
        run_job(len, reps, mdr, 32'hFFFF_FFFF, 1'b1, 30'd0,
                ($urandom_range(0, 5) == 0) ? 0 : -1, -1);
      end else begin
        reject_job(len, reps, mdr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
